ws2812_pixel_rx: RTL and testbench
==================================

WS2812_PIXEL_RX -- requirements
Module: ws2812_pixel_rx

Interface
REQ-001 Parameter CHANNELS, default 3, colour bytes per pixel (3 = GRB, 4 = GRBW); legal 1..4.
REQ-002 Parameter FIX_LEVEL, default 50, clk cycles after a din rising edge at which the bit value is sampled; legal 2..254.
REQ-003 Parameter RESET_LEVEL, default 3000, consecutive low cycles of synchronised din that constitute a line reset; legal FIX_LEVEL+2..65535.
REQ-004 Parameter LATCH_ON_RESET, default 1; 1 = q updates at line reset, 0 = q updates immediately after the last bit.
REQ-005 Parameter PWM_BITS, default 8, PWM counter width; legal 1..8; compare uses the top PWM_BITS bits of each byte.
REQ-006 Port clk  input  1  single system clock; all state on rising edge.
REQ-007 Port rst  input  1  asynchronous, active-high reset.
REQ-008 Port din  input  1  serial pixel stream; asynchronous to clk.
REQ-009 Port dout  output  1  downstream stream; raw din when passing, else 0.
REQ-010 Port q  output  8*CHANNELS  displayed colour; byte c at [8c+7:8c], byte 0 = first received.
REQ-011 Port pwm  output  CHANNELS  registered PWM drive, bit c for byte c.
REQ-012 Port frame_done  output  1  one-cycle pulse when q is updated.

Function
REQ-013 din SHALL pass a 2-flop synchroniser; s = second flop, s_d = s delayed one cycle; rise = !s_d && s.
REQ-014 Low counter (16 bit) SHALL clear when s=1, else increment saturating at RESET_LEVEL; line_reset = (count == RESET_LEVEL), asserted on every cycle while saturated.
REQ-015 Bit timer (8 bit) SHALL clear on rise, else increment saturating at FIX_LEVEL+1; bit_fix = (timer == FIX_LEVEL) for exactly one cycle per rise.
REQ-016 At bit_fix, the sampled bit SHALL be s (1 = long high, 0 = short high).
REQ-017 FSM states: CAPTURE, PASS_WAIT, PASS.
REQ-018 CAPTURE: each bit_fix shifts the bit into a staging register MSB-first within each byte, bytes in arrival order; bit counter (6 bit) increments.
REQ-019 On bit_fix with bit counter == 8*CHANNELS-1: staging completes, FSM -> PASS_WAIT, bit counter holds.
REQ-020 PASS_WAIT -> PASS on the first cycle with s == 0 (end of the last high pulse); dout = 0 in CAPTURE and PASS_WAIT.
REQ-021 PASS: dout = din (combinational, unsynchronised); bit_fix ignored; staging frozen.
REQ-022 line_reset in any state SHALL force CAPTURE, bit counter = 0, dout = 0 next cycle; line_reset wins over a coincident bit_fix.
REQ-023 LATCH_ON_RESET=1: completed staging is held pending; on the first line_reset cycle with pending set, q <= staging, frame_done pulses, pending clears; line_reset with no completed frame leaves q unchanged and no pulse.
REQ-024 LATCH_ON_RESET=0: q <= completed staging and frame_done pulses in the cycle after the last bit_fix.
REQ-025 Partial frame (fewer than 8*CHANNELS bits before line_reset) SHALL be discarded; q unchanged.
REQ-026 PWM counter SHALL free-run, wrapping 2^PWM_BITS-1 -> 0; pwm[c] <= (counter < top PWM_BITS of byte c of q); byte 0 never reaches 100 % (255/256 max at PWM_BITS=8).

Reset
REQ-027 rst SHALL asynchronously set: sync flops 0, low counter 0, bit timer FIX_LEVEL+1, bit counter 0, FSM CAPTURE, staging 0, pending 0, q 0, pwm 0, PWM counter 0, frame_done 0, dout 0.
REQ-028 After rst deassertion no bit is sampled until a rise is observed.

Verification
REQ-029 CHANNELS=3, LATCH_ON_RESET=1: 24 bits encoding 0x12,0x34,0x56 then 3000+ low cycles -> q = 0x563412 (byte 0 = 0x12), frame_done one pulse at line_reset, dout 0 throughout frame.
REQ-030 Two-pixel stream (48 bits, second pixel 0xFF,0x00,0x80): dout low for first 24 bits, then reproduces exactly bits 25..48 of din starting after the falling edge of bit 24.
REQ-031 20 bits then line_reset -> q keeps previous value, no frame_done; next full frame 0xAA,0xBB,0xCC captured correctly.
REQ-032 CHANNELS=4, LATCH_ON_RESET=0: 32 bits 0x01,0x02,0x03,0x04 -> q = 0x04030201 and frame_done one cycle after 32nd bit_fix, before any line reset.
REQ-033 q byte 0 = 0x40, PWM_BITS=8: pwm[0] high exactly 64 of each 256 cycles; byte = 0x00 -> always low.
REQ-034 rst asserted mid-frame (bit 10) and in PASS -> all outputs 0 immediately, new full frame after release captured correctly.

Source files
------------

// File: rtl/ws2812_pixel_rx.sv
// WS2812-style pixel receiver.
// Decodes the self-clocked serial stream into CHANNELS colour bytes and
// forwards the remainder of the stream downstream once its own pixel is full.
// The captured colour is shown on q and drives one PWM output per channel.
`timescale 1ns/1ps

module ws2812_pixel_rx #(
  parameter int CHANNELS       = 3,
  parameter int FIX_LEVEL      = 50,
  parameter int RESET_LEVEL    = 3000,
  parameter bit LATCH_ON_RESET = 1'b1,
  parameter int PWM_BITS       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  output logic                    dout,
  output logic [8*CHANNELS-1:0]   q,
  output logic [CHANNELS-1:0]     pwm,
  output logic                    frame_done
);

  localparam int          STG_W    = 8 * CHANNELS;
  localparam logic [15:0] LOW_MAX  = 16'(RESET_LEVEL);
  localparam logic [7:0]  FIX_CNT  = 8'(FIX_LEVEL);
  localparam logic [7:0]  TMR_MAX  = 8'(FIX_LEVEL + 1);
  localparam logic [5:0]  LAST_BIT = 6'(STG_W - 1);

  typedef enum logic [1:0] {
    CAPTURE   = 2'd0,
    PASS_WAIT = 2'd1,
    PASS      = 2'd2
  } state_t;

  logic                 sync1_q, sync2_q, s_dly_q;
  logic [15:0]          low_cnt_q;
  logic [7:0]           bit_tmr_q;
  logic [5:0]           bit_cnt_q;
  state_t               state_q;
  logic [STG_W-1:0]     staging_q, staging_d;
  logic                 pending_q;
  logic [STG_W-1:0]     q_q;
  logic [CHANNELS-1:0]  pwm_q;
  logic [PWM_BITS-1:0]  pwm_cnt_q;
  logic                 frame_done_q;

  logic       rise, line_reset, bit_fix, capture_fix, last_bit;
  logic [5:0] stg_idx;

  assign rise        = ~s_dly_q & sync2_q;
  assign line_reset  = (low_cnt_q == LOW_MAX);
  assign bit_fix     = (bit_tmr_q == FIX_CNT);
  assign capture_fix = (state_q == CAPTURE) && bit_fix && !line_reset;
  assign last_bit    = capture_fix && (bit_cnt_q == LAST_BIT);
  // Bytes fill in arrival order, each byte MSB first: index = 8*byte + (7-bit).
  assign stg_idx     = {bit_cnt_q[5:3], ~bit_cnt_q[2:0]};

  // Next staging contents: write the sampled bit into its slot on a capture.
  always_comb begin
    staging_d = staging_q;
    if (capture_fix) begin
      for (int i = 0; i < STG_W; i++) begin
        if (6'(i) == stg_idx) staging_d[i] = sync2_q;
      end
    end
  end

  // Two-flop synchroniser for din plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      s_dly_q <= sync2_q;
    end
  end

  // Low-time counter; saturates and stays in line_reset while din is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_cnt_q <= 16'd0;
    end else if (sync2_q) begin
      low_cnt_q <= 16'd0;
    end else if (low_cnt_q != LOW_MAX) begin
      low_cnt_q <= low_cnt_q + 16'd1;
    end
  end

  // Bit timer restarted by each rising edge; parks above FIX_LEVEL so that
  // bit_fix fires once per edge and never right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_tmr_q <= TMR_MAX;
    end else if (rise) begin
      bit_tmr_q <= 8'd0;
    end else if (bit_tmr_q != TMR_MAX) begin
      bit_tmr_q <= bit_tmr_q + 8'd1;
    end
  end

  // Capture / pass-through sequencer with frame latching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CAPTURE;
      bit_cnt_q    <= 6'd0;
      staging_q    <= '0;
      pending_q    <= 1'b0;
      q_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      staging_q    <= staging_d;
      if (line_reset) begin
        state_q   <= CAPTURE;
        bit_cnt_q <= 6'd0;
        if (LATCH_ON_RESET && pending_q) begin
          q_q          <= staging_q;
          frame_done_q <= 1'b1;
          pending_q    <= 1'b0;
        end
      end else begin
        case (state_q)
          CAPTURE: begin
            if (capture_fix) begin
              if (last_bit) begin
                state_q <= PASS_WAIT;
                if (LATCH_ON_RESET) begin
                  pending_q <= 1'b1;
                end else begin
                  q_q          <= staging_d;
                  frame_done_q <= 1'b1;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 6'd1;
              end
            end
          end
          // Hold off forwarding until our last high pulse has ended.
          PASS_WAIT: if (!sync2_q) state_q <= PASS;
          PASS:      state_q <= PASS;
          default:   state_q <= CAPTURE;
        endcase
      end
    end
  end

  // Free-running PWM counter compared with the top PWM_BITS of each byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      pwm_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
        pwm_q[c] <= (pwm_cnt_q < q_q[8*c+7 -: PWM_BITS]);
      end
    end
  end

  // Forwarding uses raw din so downstream pulse widths are not distorted.
  assign dout       = (state_q == PASS) & din;
  assign q          = q_q;
  assign pwm        = pwm_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_pixel_rx.sv
// Testbench for ws2812_pixel_rx: instance A (3 channels, latch on reset,
// default timing) and instance B (4 channels, immediate latch, short timing).
`timescale 1ns/1ps

module tb_ws2812_pixel_rx;

  localparam int A_FIX = 50;
  localparam int A_RST = 3000;
  localparam int B_FIX = 12;
  localparam int B_RST = 100;
  localparam int B_PWM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, din_a = 1'b0, dout_a, fd_a;
  logic [23:0] q_a;
  logic [2:0]  pwm_a;
  logic        rst_b = 1'b1, din_b = 1'b0, dout_b, fd_b;
  logic [31:0] q_b;
  logic [3:0]  pwm_b;

  ws2812_pixel_rx #(
    .CHANNELS(3), .FIX_LEVEL(A_FIX), .RESET_LEVEL(A_RST),
    .LATCH_ON_RESET(1'b1), .PWM_BITS(8)
  ) dut_a (
    .clk(clk), .rst(rst_a), .din(din_a), .dout(dout_a),
    .q(q_a), .pwm(pwm_a), .frame_done(fd_a)
  );

  ws2812_pixel_rx #(
    .CHANNELS(4), .FIX_LEVEL(B_FIX), .RESET_LEVEL(B_RST),
    .LATCH_ON_RESET(1'b0), .PWM_BITS(B_PWM)
  ) dut_b (
    .clk(clk), .rst(rst_b), .din(din_b), .dout(dout_b),
    .q(q_b), .pwm(pwm_b), .frame_done(fd_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors sampled just after each rising edge.
  int          fd_cnt_a = 0, fd_cnt_b = 0, dout_hi_a = 0, dout_hi_b = 0;
  bit          mon_dout_a = 1'b0, dec_en = 1'b0;
  int          dec_w = 0, dec_n = 0;
  logic [23:0] dec_bits = '0;

  always @(posedge clk) begin
    #2;
    if (fd_a) fd_cnt_a <= fd_cnt_a + 1;
    if (fd_b) fd_cnt_b <= fd_cnt_b + 1;
    if (mon_dout_a && dout_a) dout_hi_a <= dout_hi_a + 1;
    if (dout_b) dout_hi_b <= dout_hi_b + 1;
    // Decode forwarded pulses on dout_a by their high width.
    if (!dec_en) begin
      dec_w    <= 0;
      dec_n    <= 0;
      dec_bits <= '0;
    end else if (dout_a) begin
      dec_w <= dec_w + 1;
    end else if (dec_w > 0) begin
      dec_bits <= {dec_bits[22:0], 1'(dec_w > A_FIX)};
      dec_n    <= dec_n + 1;
      dec_w    <= 0;
    end
  end

  // Instance A bit: 75 cycles high for 1, 25 for 0, 100-cycle period.
  task automatic send_bit_a(input logic b);
    int hi;
    hi = b ? 75 : 25;
    din_a = 1'b1;
    repeat (hi) @(negedge clk);
    din_a = 1'b0;
    repeat (100 - hi) @(negedge clk);
  endtask

  task automatic send_stream_a(input logic [23:0] stream, input int n);
    for (int i = 0; i < n; i++) send_bit_a(stream[23-i]);
  endtask

  // Instance B bit with randomised pulse and gap widths inside the legal windows.
  task automatic send_bit_b(input logic b);
    int hi, lo;
    hi = b ? int'($urandom_range(17, 22)) : int'($urandom_range(3, 7));
    lo = b ? int'($urandom_range(6, 10))  : int'($urandom_range(14, 18));
    din_b = 1'b1;
    repeat (hi) @(negedge clk);
    din_b = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_stream_b(input logic [31:0] stream, input int n);
    for (int i = 0; i < n; i++) send_bit_b(stream[31-i]);
  endtask

  typedef struct {
    logic [23:0] stream;
    int          nbits;
    int          exp_done;
    logic [23:0] exp_q;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int fd0, dh0, k, cnt;
    logic [7:0]  by[4];
    logic [31:0] model_q;
    int          n;

    vecs[0] = '{24'h123456, 24, 1, 24'h563412};
    vecs[1] = '{24'hABCDEF, 20, 0, 24'h563412};
    vecs[2] = '{24'hAABBCC, 24, 1, 24'hCCBBAA};
    vecs[3] = '{24'h4000FF, 24, 1, 24'hFF0040};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_q_a", q_a, 0);
    check("rst_pwm_a", pwm_a, 0);
    check("rst_fd_a", fd_a, 0);
    check("rst_dout_a", dout_a, 0);
    check("rst_q_b", q_b, 0);
    check("rst_pwm_b", {fd_b, dout_b, pwm_b}, 0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);

    // Table-driven frames on instance A
    for (int v = 0; v < 4; v++) begin
      fd0 = fd_cnt_a;
      dh0 = dout_hi_a;
      mon_dout_a = 1'b1;
      send_stream_a(vecs[v].stream, vecs[v].nbits);
      repeat (A_RST + 20) @(negedge clk);
      mon_dout_a = 1'b0;
      check($sformatf("vec%0d_q", v), q_a, vecs[v].exp_q);
      check($sformatf("vec%0d_done", v), fd_cnt_a - fd0, vecs[v].exp_done);
      check($sformatf("vec%0d_dout", v), dout_hi_a - dh0, 0);
    end

    // PWM duty for q bytes 0x40, 0x00, 0xFF
    for (int c = 0; c < 3; c++) begin
      cnt = 0;
      for (int t = 0; t < 256; t++) begin
        @(negedge clk);
        if (pwm_a[c]) cnt++;
      end
      check($sformatf("pwm_a%0d", c), cnt, (c == 0) ? 64 : (c == 1) ? 0 : 255);
    end

    // Two-pixel stream: first pixel captured, second forwarded on dout
    fd0 = fd_cnt_a;
    dh0 = dout_hi_a;
    mon_dout_a = 1'b1;
    send_stream_a(24'h112233, 24);
    mon_dout_a = 1'b0;
    check("two_px_dout_first", dout_hi_a - dh0, 0);
    dec_en = 1'b1;
    send_stream_a(24'hFF0080, 24);
    repeat (20) @(negedge clk);
    check("two_px_fwd_count", dec_n, 24);
    check("two_px_fwd_bits", dec_bits, 24'hFF0080);
    dec_en = 1'b0;
    repeat (A_RST + 20) @(negedge clk);
    check("two_px_q", q_a, 24'h332211);
    check("two_px_done", fd_cnt_a - fd0, 1);
    check("two_px_dout_idle", dout_a, 0);

    // Reset mid-frame during bit 10
    send_stream_a(24'h5A5A5A, 9);
    din_a = 1'b1;
    repeat (10) @(negedge clk);
    rst_a = 1'b1;
    #1;
    check("midrst_q", q_a, 0);
    check("midrst_outs", {pwm_a, fd_a, dout_a}, 0);
    din_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);
    fd0 = fd_cnt_a;
    send_stream_a(24'h9ABCDE, 24);
    repeat (A_RST + 20) @(negedge clk);
    check("midrst_new_q", q_a, 24'hDEBC9A);
    check("midrst_new_done", fd_cnt_a - fd0, 1);

    // Reset while forwarding
    send_stream_a(24'h123456, 24);
    din_a = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("pass_dout_on", dout_a, 1);
    rst_a = 1'b1;
    #1;
    check("passrst_dout", dout_a, 0);
    check("passrst_q", q_a, 0);
    check("passrst_outs", {pwm_a, fd_a}, 0);
    din_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);
    fd0 = fd_cnt_a;
    send_stream_a(24'h0F1E2D, 24);
    repeat (A_RST + 20) @(negedge clk);
    check("passrst_new_q", q_a, 24'h2D1E0F);
    check("passrst_new_done", fd_cnt_a - fd0, 1);

    // Instance B: immediate latch, frame_done right after the last bit
    fd0 = fd_cnt_b;
    dh0 = dout_hi_b;
    send_stream_b(32'h01020304, 31);
    din_b = 1'b1;
    k = -1;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (t == 5) din_b = 1'b0;
      if (fd_b) begin
        k = t;
        break;
      end
    end
    check("b_done_in_window", (k >= B_FIX + 3 && k <= B_FIX + 5) ? 1 : 0, 1);
    check("b_q_before_reset", q_b, 32'h04030201);
    repeat (20) @(negedge clk);
    check("b_done_once", fd_cnt_b - fd0, 1);
    check("b_dout_frame", dout_hi_b - dh0, 0);
    repeat (B_RST + 20) @(negedge clk);
    check("b_no_pulse_at_reset", fd_cnt_b - fd0, 1);

    // Randomised frames on instance B against a byte-level model
    model_q = 32'h04030201;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 4; c++) by[c] = 8'($urandom_range(0, 255));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 32;
      if (n == 32) model_q = {by[3], by[2], by[1], by[0]};
      fd0 = fd_cnt_b;
      send_stream_b({by[0], by[1], by[2], by[3]}, n);
      repeat (B_RST + 20) @(negedge clk);
      check($sformatf("rnd%0d_q", r), q_b, model_q);
      check($sformatf("rnd%0d_done", r), fd_cnt_b - fd0, (n == 32) ? 1 : 0);
      for (int c = 0; c < 4; c++) begin
        cnt = 0;
        for (int t = 0; t < (1 << B_PWM); t++) begin
          @(negedge clk);
          if (pwm_b[c]) cnt++;
        end
        check($sformatf("rnd%0d_pwm%0d", r, c), cnt, 32'(model_q[8*c +: 8] >> (8 - B_PWM)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
